aes_sbox_array: RTL and testbench

AES_SBOX_ARRAY -- requirements
Module: aes_sbox_array

---
 rtl/aes_sbox_array.sv | 201 ++++++++++++++++++++
 tb/tb_aes_sbox_array.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_sbox_array                                               |
// | Description : LANES parallel AES byte substitutions behind a LAT-stage     |
// |               valid/ready pipeline with a single global advance signal.    |
// |               Forward S-box always available; inverse S-box and the        |
// |               per-transfer in_inv selection exist only when the macro      |
// |               AES_SBOX_INV_EN is defined (otherwise out_inv reads 0).      |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               in_valid/in_ready/in_data[8*LANES]/in_inv  - input transfer  |
// |               out_valid/out_ready/out_data[8*LANES]/out_inv - result       |
// |               xfer_cnt[16] - completed output transfers, wraps             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_sbox_array #(
    parameter int LANES = 4,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_inv,
    output logic [15:0]          xfer_cnt
);

    localparam int c_data_w = 8 * LANES;
`ifdef AES_SBOX_INV_EN
    localparam logic c_inv_en = 1'b1;
`else
    localparam logic c_inv_en = 1'b0;
`endif

    // The S-box is computed rather than tabulated: multiplicative inverse in
    // GF(2^8) (x^254, which also maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Square-and-multiply over exponent bits 1..7 accumulates a^254.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

`ifdef AES_SBOX_INV_EN
    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    endfunction
`endif

    logic                advance;
    logic [c_data_w-1:0] lk_src;
    logic [c_data_w-1:0] lk_data;
    logic                nxt_valid;
    logic                nxt_inv;
`ifdef AES_SBOX_INV_EN
    logic                lk_inv;
`endif

    logic                out_valid_q, out_valid_d;
    logic                out_inv_q, out_inv_d;
    logic [c_data_w-1:0] out_data_q, out_data_d;
    logic [15:0]         xfer_cnt_q, xfer_cnt_d;

    // Whole pipeline moves together; only a stalled, occupied last stage
    // blocks it.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    generate
        if (LAT >= 2) begin : g_lat2
            // Stage 1 registers the raw input; the lookup sits between stages.
            logic                s1_valid_q, s1_valid_d;
            logic                s1_inv_q, s1_inv_d;
            logic [c_data_w-1:0] s1_data_q, s1_data_d;

            always_comb begin
                s1_valid_d = s1_valid_q;
                s1_inv_d   = s1_inv_q;
                s1_data_d  = s1_data_q;
                if (advance) begin
                    s1_valid_d = in_valid;
                    if (in_valid) begin
                        s1_data_d = in_data;
                        s1_inv_d  = in_inv & c_inv_en;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_inv_q   <= 1'b0;
                    s1_data_q  <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_inv_q   <= s1_inv_d;
                    s1_data_q  <= s1_data_d;
                end
            end

            assign lk_src    = s1_data_q;
            assign nxt_valid = s1_valid_q;
            assign nxt_inv   = s1_inv_q;
`ifdef AES_SBOX_INV_EN
            assign lk_inv    = s1_inv_q;
`endif
        end else begin : g_lat1
            // Single stage: lookup directly on the input bus.
            assign lk_src    = in_data;
            assign nxt_valid = in_valid;
            assign nxt_inv   = in_inv & c_inv_en;
`ifdef AES_SBOX_INV_EN
            assign lk_inv    = in_inv;
`endif
        end
    endgenerate

    always_comb begin
        lk_data = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef AES_SBOX_INV_EN
            if (lk_inv)
                lk_data[8*i +: 8] = gf_inv(inv_affine(lk_src[8*i +: 8]));
            else
                lk_data[8*i +: 8] = fwd_affine(gf_inv(lk_src[8*i +: 8]));
`else
            lk_data[8*i +: 8] = fwd_affine(gf_inv(lk_src[8*i +: 8]));
`endif
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_inv_d   = out_inv_q;
        xfer_cnt_d  = xfer_cnt_q + {15'd0, (out_valid_q && out_ready)};
        if (advance) begin
            out_valid_d = nxt_valid;
            // Payload only reloads for real data; bubbles leave it untouched.
            if (nxt_valid) begin
                out_data_d = lk_data;
                out_inv_d  = nxt_inv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inv_q   <= 1'b0;
            out_data_q  <= '0;
            xfer_cnt_q  <= 16'h0000;
        end else begin
            out_valid_q <= out_valid_d;
            out_inv_q   <= out_inv_d;
            out_data_q  <= out_data_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_inv   = out_inv_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aes_sbox_array                                            |
// | Description : Self-checking bench for aes_sbox_array: directed vector      |
// |               table, back-pressure stream, reset mid-flight, counter wrap  |
// |               and full byte sweeps on LANES=1/16 x LAT=1/2 instances.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_aes_sbox_array;

`ifdef AES_SBOX_INV_EN
    localparam bit c_inv_en = 1'b1;
`else
    localparam bit c_inv_en = 1'b0;
`endif

    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_fail;

    // main instance: LANES=4, LAT=2
    logic        m_valid, m_irdy, m_inv, m_ovalid, m_ordy, m_oinv;
    logic [31:0] m_din, m_dout;
    logic [15:0] m_cnt;

    // sweep instances
    logic        sw_valid, sw_inv, sw_ordy;
    logic [7:0]  sw_x;
    logic [127:0] sw_od [4];
    logic        sw_ov [4];
    logic        sw_oinv [4];
    logic        sw_ir [4];
    logic [15:0] sw_cnt [4];

    logic [7:0]  fwd_tab [256];
    logic [7:0]  inv_tab [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_sbox_array #(.LANES(4), .LAT(2)) u_main (
        .clk(clk), .rst(rst),
        .in_valid(m_valid), .in_ready(m_irdy), .in_data(m_din), .in_inv(m_inv),
        .out_valid(m_ovalid), .out_ready(m_ordy), .out_data(m_dout), .out_inv(m_oinv),
        .xfer_cnt(m_cnt)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sweep
        localparam int c_l = (k < 2) ? 1 : 16;
        localparam int c_p = (k % 2) + 1;
        logic [8*c_l-1:0] din;
        logic [8*c_l-1:0] dout;
        logic             ov, oinv, ir;
        logic [15:0]      cnt;

        always_comb begin
            din = '0;
            for (int i = 0; i < c_l; i++) din[8*i +: 8] = sw_x + 8'(i);
        end

        aes_sbox_array #(.LANES(c_l), .LAT(c_p)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(sw_valid), .in_ready(ir), .in_data(din), .in_inv(sw_inv),
            .out_valid(ov), .out_ready(sw_ordy), .out_data(dout), .out_inv(oinv),
            .xfer_cnt(cnt)
        );

        assign sw_od[k]   = 128'(dout);
        assign sw_ov[k]   = ov;
        assign sw_oinv[k] = oinv;
        assign sw_ir[k]   = ir;
        assign sw_cnt[k]  = cnt;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference substitution from the FIPS-197 table held in the bench.
    function automatic logic [7:0] ref_sub(input logic [7:0] x, input logic inv);
        return (inv && c_inv_en) ? inv_tab[x] : fwd_tab[x];
    endfunction

    function automatic logic [127:0] sweep_exp(input int lanes, input int j);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < lanes; i++)
            r[8*i +: 8] = ref_sub(8'((j + i) & 255), j >= 256);
        return r;
    endfunction

    function automatic logic [31:0] exp4(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_sub(d[8*i +: 8], 1'b0);
        return r;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        m_valid = 1'b0;
        sw_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] din;
        logic        inv;
        logic [31:0] dout;
        logic        oinv;
    } vec_t;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs [6];
        logic [2047:0] fwd_all;
        logic [31:0]  vals [8];
        logic [31:0]  held_data;
        logic         held;
        int           sent, got;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        m_valid  = 1'b0;
        m_din    = '0;
        m_inv    = 1'b0;
        m_ordy   = 1'b1;
        sw_valid = 1'b0;
        sw_inv   = 1'b0;
        sw_x     = 8'h00;
        sw_ordy  = 1'b1;

        fwd_all = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int v = 0; v < 256; v++) fwd_tab[v] = fwd_all[2047 - 8*v -: 8];
        for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);

        // directed vectors, hand-computed from FIPS-197
        vecs[0] = '{32'hFF530100, 1'b0, 32'h16ED7C63, 1'b0};
        vecs[2] = '{32'h00000000, 1'b0, 32'h63636363, 1'b0};
        vecs[3] = '{32'h12345678, 1'b0, 32'hC918B1BC, 1'b0};
`ifdef AES_SBOX_INV_EN
        vecs[1] = '{32'h16ED7C63, 1'b1, 32'hFF530100, 1'b1};
        vecs[4] = '{32'h63636363, 1'b1, 32'h00000000, 1'b1};
        vecs[5] = '{32'hC918B1BC, 1'b1, 32'h12345678, 1'b1};
`else
        vecs[1] = '{32'h16ED7C63, 1'b1, 32'h475510FB, 1'b0};
        vecs[4] = '{32'h63636363, 1'b1, 32'hFBFBFBFB, 1'b0};
        vecs[5] = '{32'hC918B1BC, 1'b1, 32'hDDADC865, 1'b0};
`endif

        // ---------------- reset state ----------------
        do_reset();
        check("rst_out_valid", {127'd0, m_ovalid}, 128'd0);
        check("rst_xfer_cnt", {112'd0, m_cnt}, 128'd0);
        check("rst_in_ready", {127'd0, m_irdy}, 128'd1);
        check("rst_out_data", {96'd0, m_dout}, 128'd0);
        check("rst_out_inv", {127'd0, m_oinv}, 128'd0);

        // ---------------- directed vector table ----------------
        for (int v = 0; v < 6; v++) begin
            m_valid = 1'b1;
            m_din   = vecs[v].din;
            m_inv   = vecs[v].inv;
            m_ordy  = 1'b1;
            @(posedge clk); #1;
            m_valid = 1'b0;
            m_din   = 32'hDEADBEEF;
            check("vec_not_early", {127'd0, m_ovalid}, 128'd0);
            @(posedge clk); #1;
            check("vec_valid", {127'd0, m_ovalid}, 128'd1);
            check("vec_data", {96'd0, m_dout}, {96'd0, vecs[v].dout});
            check("vec_inv", {127'd0, m_oinv}, {127'd0, vecs[v].oinv});
            @(posedge clk); #1;
            check("vec_one_cycle", {127'd0, m_ovalid}, 128'd0);
            check("vec_cnt", {112'd0, m_cnt}, 128'(v + 1));
        end

        // ---------------- back-pressure stream ----------------
        do_reset();
        for (int j = 0; j < 8; j++)
            vals[j] = {8'(j), 8'(j + 16), 8'(j * 37), 8'hA5 ^ 8'(j)};
        sent = 0;
        got  = 0;
        held = 1'b0;
        held_data = '0;
        for (int c = 0; c < 30; c++) begin
            m_ordy  = !(c >= 3 && c <= 5);
            m_valid = (sent < 8);
            m_din   = (sent < 8) ? vals[sent] : 32'h0;
            m_inv   = 1'b0;
            #1;
            if (c < 12) check("bp_in_ready", {127'd0, m_irdy}, {127'd0, !(c >= 3 && c <= 5)});
            if (held) check("bp_hold", {96'd0, m_dout}, {96'd0, held_data});
            if (m_ovalid && m_ordy) begin
                if (got < 8) check("bp_data", {96'd0, m_dout}, {96'd0, exp4(vals[got])});
                else check("bp_extra_out", 128'(got), 128'd7);
                got++;
            end
            held      = m_ovalid && !m_ordy;
            held_data = m_dout;
            if (m_valid && m_irdy) sent++;
            @(posedge clk); #1;
        end
        check("bp_sent", 128'(sent), 128'd8);
        check("bp_got", 128'(got), 128'd8);
        check("bp_cnt", {112'd0, m_cnt}, 128'd8);

        // ---------------- reset with transfers in flight ----------------
        do_reset();
        m_ordy  = 1'b1;
        m_valid = 1'b1;
        m_din   = 32'h01020304;
        @(posedge clk); #1;
        m_din   = 32'hA0B0C0D0;
        @(posedge clk); #1;
        m_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        check("midrst_out_valid", {127'd0, m_ovalid}, 128'd0);
        check("midrst_cnt", {112'd0, m_cnt}, 128'd0);
        check("midrst_in_ready", {127'd0, m_irdy}, 128'd1);
        check("midrst_out_data", {96'd0, m_dout}, 128'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("midrst_no_ghost", {127'd0, m_ovalid}, 128'd0);
        end
        check("midrst_cnt_after", {112'd0, m_cnt}, 128'd0);

        // ---------------- full byte sweeps ----------------
        do_reset();
        for (int t = 0; t < 514; t++) begin
            sw_valid = (t < 512);
            sw_x     = 8'(t);
            sw_inv   = (t >= 256);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                int lanes;
                int lat;
                int j;
                lanes = (k < 2) ? 1 : 16;
                lat   = (k % 2) + 1;
                j     = t - lat + 1;
                check("sw_in_ready", {127'd0, sw_ir[k]}, 128'd1);
                check("sw_valid", {127'd0, sw_ov[k]}, {127'd0, (j >= 0 && j < 512)});
                if (j >= 0 && j < 512) begin
                    check("sw_data", sw_od[k], sweep_exp(lanes, j));
                    check("sw_inv", {127'd0, sw_oinv[k]}, {127'd0, (j >= 256) && c_inv_en});
                end
            end
        end
        for (int k = 0; k < 4; k++) check("sw_cnt", {112'd0, sw_cnt[k]}, 128'd512);

        // ---------------- transfer counter wrap ----------------
        do_reset();
        m_ordy = 1'b1;
        m_inv  = 1'b0;
        m_din  = 32'h00112233;
        for (int k = 0; k < 65539; k++) begin
            m_valid = (k < 65537);
            @(posedge clk); #1;
            if (k == 65536) check("wrap_ffff", {112'd0, m_cnt}, 128'h0FFFF);
            if (k == 65537) check("wrap_0000", {112'd0, m_cnt}, 128'h00000);
            if (k == 65538) check("wrap_0001", {112'd0, m_cnt}, 128'h00001);
        end
        m_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
